// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_pkg
// Brief    : Shared mode/state encodings for the parametrised ring shifter.
// Revision : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    typedef enum logic [2:0] {
        ROTL = 3'd0,
        ROTR = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ASR  = 3'd4,
        LOAD = 3'd5,
        RSV6 = 3'd6,
        RSV7 = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_reserved(input mode_e m);
        return (m == RSV6) || (m == RSV7);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_reg_next.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_next
// Brief    : Combinational single-step next value and serial-out bit.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_next
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic             ser_out
);

    always_comb begin
        q_next  = q;
        ser_out = q[WIDTH-1];
        case (mode)
            ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            ROTR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                ser_out = q[0];
            end
            SHL:  q_next = {q[WIDTH-2:0], ser_in};
            SHR: begin
                q_next  = {ser_in, q[WIDTH-1:1]};
                ser_out = q[0];
            end
            ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                ser_out = q[0];
            end
            // LOAD is applied by the controller on the start edge; here it holds
            default: q_next = q;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ring_shift_reg_param.sv
`default_nettype none
// ============================================================================
// Module   : ring_shift_reg_param
// Brief    : Parametrised ring/shift register with start/busy/done multi-step
//            sequencing. Optional legacy single-step input: RING_SHIFT_REG_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ring_shift_reg_param
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               CNT_W   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
`ifdef RING_SHIFT_REG_STEP_EN
    input  logic             step,
`endif
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    mode_e              mode_q,  mode_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   q_q,     q_d;
    logic [WIDTH-1:0]   w_q_next;
    mode_e              w_mode_in;

    assign w_mode_in = mode_e'(mode);

    shift_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q       (q_q),
        .mode    (mode_q),
        .ser_in  (ser_in),
        .q_next  (w_q_next),
        .ser_out (ser_out)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = w_mode_in;
                    if (w_mode_in == LOAD) begin
                        q_d     = load_data;
                        state_d = DONE;
                    end else if ((amount == '0) || is_reserved(w_mode_in)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = amount;
                        state_d = RUN;
                    end
                end
`ifdef RING_SHIFT_REG_STEP_EN
                // Legacy ring-counter advance; never touches the FSM
                else if (step) begin
                    q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                end
`endif
            end
            RUN: begin
                q_d   = w_q_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= ROTL;
            cnt_q   <= '0;
            q_q     <= RST_VAL;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    assign q    = q_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_ring_shift_reg_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_shift_reg_param
// Brief    : Self-checking bench for ring_shift_reg_param (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_shift_reg_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [3:0] amount = 4'd0;
    logic [7:0] load_data = 8'd0;
    logic       ser_in = 1'b0;
    logic       step = 1'b0;
    logic [7:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q = 8'h01;

    ring_shift_reg_param dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .load_data (load_data),
        .ser_in    (ser_in),
`ifdef RING_SHIFT_REG_STEP_EN
        .step      (step),
`endif
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference step: plain integer arithmetic on the 8-bit value
    function automatic logic [7:0] ref_step(input logic [7:0] v, input logic [2:0] m, input logic s);
        int x;
        int r;
        x = int'(v);
        case (m)
            3'd0:    r = (x << 1) | (x >> 7);
            3'd1:    r = (x >> 1) | (x << 7);
            3'd2:    r = (x << 1) | int'(s);
            3'd3:    r = (x >> 1) | (int'(s) << 7);
            3'd4:    r = (x >> 1) | (x & 128);
            default: r = x;
        endcase
        return r[7:0];
    endfunction

    function automatic logic ref_ser(input logic [7:0] v, input logic [2:0] m);
        return (m == 3'd1 || m == 3'd3 || m == 3'd4) ? v[0] : v[7];
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE
    task automatic run_op(input logic [2:0] m, input int amt, input logic [7:0] ld,
                          input bit use_pat, input logic [15:0] pat);
        int   steps;
        logic s;
        logic eb;
        logic ed;
        start     = 1'b1;
        mode      = m;
        amount    = 4'(amt);
        load_data = ld;
        ser_in    = 1'($urandom);
        steps     = (m == 3'd5 || amt == 0 || m >= 3'd6) ? 0 : amt;
        for (int k = 0; k <= steps; k++) begin
            if (k == 0) begin
                @(posedge clk);
                @(negedge clk);
                if (m == 3'd5) exp_q = ld;
            end else begin
                s         = use_pat ? pat[k-1] : 1'($urandom);
                ser_in    = s;
                start     = 1'($urandom);
                mode      = 3'($urandom);
                amount    = 4'($urandom);
                load_data = 8'($urandom);
                step      = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
                exp_q = ref_step(exp_q, m, s);
            end
            eb = (k < steps);
            ed = (k == steps);
            n_cmp++;
            if (q !== exp_q) begin
                n_bad++;
                $display("FAIL op_q m=%0d amt=%0d k=%0d got=%h exp=%h", m, amt, k, q, exp_q);
            end
            n_cmp++;
            if (busy !== eb) begin
                n_bad++;
                $display("FAIL op_busy m=%0d amt=%0d k=%0d got=%b exp=%b", m, amt, k, busy, eb);
            end
            n_cmp++;
            if (done !== ed) begin
                n_bad++;
                $display("FAIL op_done m=%0d amt=%0d k=%0d got=%b exp=%b", m, amt, k, done, ed);
            end
            n_cmp++;
            if (ser_out !== ref_ser(exp_q, m)) begin
                n_bad++;
                $display("FAIL op_ser m=%0d amt=%0d k=%0d got=%b exp=%b", m, amt, k, ser_out, ref_ser(exp_q, m));
            end
        end
        // start during DONE must be ignored
        start     = 1'b1;
        mode      = 3'($urandom_range(0, 4));
        amount    = 4'($urandom_range(1, 15));
        load_data = 8'($urandom);
        step      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (q !== exp_q || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL op_idle m=%0d q=%h busy=%b done=%b exp_q=%h exp_busy=0 exp_done=0", m, q, busy, done, exp_q);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        step  = 1'b0;
        @(negedge clk);
        exp_q = 8'h01;
        n_cmp++;
        if (q !== 8'h01 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset q=%h busy=%b done=%b ser=%b exp 01/0/0/0", q, busy, done, ser_out);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (q !== 8'h01) begin
            n_bad++;
            $display("FAIL reset_hold got=%h exp=01", q);
        end
    endtask

    task automatic test_rotl3();
        run_op(3'd0, 3, 8'h00, 1'b0, 16'h0);
        n_cmp++;
        if (q !== 8'h08) begin
            n_bad++;
            $display("FAIL rotl3_final got=%h exp=08", q);
        end
    endtask

    task automatic test_load_asr();
        run_op(3'd5, 0, 8'hB4, 1'b0, 16'h0);
        run_op(3'd4, 2, 8'h00, 1'b0, 16'h0);
        n_cmp++;
        if (q !== 8'hED) begin
            n_bad++;
            $display("FAIL asr_final got=%h exp=ED", q);
        end
    endtask

    task automatic test_shr_toggle();
        run_op(3'd5, 0, 8'h00, 1'b0, 16'h0);
        run_op(3'd3, 8, 8'h00, 1'b1, 16'h0055);
        n_cmp++;
        if (q !== 8'h55) begin
            n_bad++;
            $display("FAIL shr_final got=%h exp=55", q);
        end
    endtask

    task automatic test_async_abort();
        do_reset();
        start  = 1'b1;
        mode   = 3'd1;
        amount = 4'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (q !== 8'h01 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_now q=%h busy=%b done=%b exp 01/0/0", q, busy, done);
        end
        @(negedge clk);
        rst   = 1'b1;
        exp_q = 8'h01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (q !== 8'h01 || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_quiet i=%0d q=%h busy=%b done=%b exp 01/0/0", i, q, busy, done);
            end
        end
        run_op(3'd1, 5, 8'h00, 1'b0, 16'h0);
        n_cmp++;
        if (q !== 8'h08) begin
            n_bad++;
            $display("FAIL abort_after got=%h exp=08", q);
        end
    endtask

    task automatic test_zero_reserved();
        run_op(3'd0, 0, 8'h00, 1'b0, 16'h0);
        run_op(3'd6, 5, 8'h00, 1'b0, 16'h0);
        run_op(3'd7, 9, 8'h00, 1'b0, 16'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                   8'($urandom), 1'b0, 16'h0);
        end
    endtask

`ifdef RING_SHIFT_REG_STEP_EN
    task automatic test_step();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            @(posedge clk);
            @(negedge clk);
            step  = 1'b0;
            exp_q = ref_step(exp_q, 3'd0, 1'b0);
            n_cmp++;
            if (q !== exp_q || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL step i=%0d q=%h busy=%b done=%b exp %h/0/0", i, q, busy, done, exp_q);
            end
        end
        step = 1'b1;
        run_op(3'd5, 0, 8'hA5, 1'b0, 16'h0);
    endtask
`endif

    initial begin
        test_reset();
        test_rotl3();
        test_load_asr();
        test_shr_toggle();
        test_async_abort();
        test_zero_reserved();
`ifdef RING_SHIFT_REG_STEP_EN
        test_step();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
